// File: rtl/cp0_pkg.sv
// Shared definitions for the MIPS coprocessor 0 block: register numbers,
// field bit positions, exception codes and the SR/Cause register layouts.
// Optional feature macro used elsewhere: CP0_TIMER_EN (Count/Compare timer).
package cp0_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned HWINT_W = 6;
   localparam int unsigned EXC_W   = 5;

   // CP0 register numbers (rd field of mfc0/mtc0)
   localparam logic [ADDR_W-1:0] CP0_COUNT   = 5'd9;
   localparam logic [ADDR_W-1:0] CP0_COMPARE = 5'd11;
   localparam logic [ADDR_W-1:0] CP0_SR      = 5'd12;
   localparam logic [ADDR_W-1:0] CP0_CAUSE   = 5'd13;
   localparam logic [ADDR_W-1:0] CP0_EPC     = 5'd14;
   localparam logic [ADDR_W-1:0] CP0_PRID    = 5'd15;

   // Field bit positions
   localparam int unsigned SR_IE_BIT    = 0;
   localparam int unsigned SR_EXL_BIT   = 1;
   localparam int unsigned SR_IM_LO     = 10;
   localparam int unsigned SR_IM_HI     = 15;
   localparam int unsigned CAUSE_EXC_LO = 2;
   localparam int unsigned CAUSE_EXC_HI = 6;
   localparam int unsigned CAUSE_IP_LO  = 10;
   localparam int unsigned CAUSE_IP_HI  = 15;
   localparam int unsigned CAUSE_BD_BIT = 31;

   // Exception codes
   localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
   localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
   localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
   localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
   localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

   typedef struct packed {
      logic [HWINT_W-1:0] im;
      logic               exl;
      logic               ie;
   } sr_t;

   typedef struct packed {
      logic               bd;
      logic [HWINT_W-1:0] ip;
      logic [EXC_W-1:0]   exc_code;
   } cause_t;

   // Place SR fields into their architectural bit positions
   function automatic logic [DATA_W-1:0] sr_word(input sr_t s);
      logic [DATA_W-1:0] w;
      w                     = '0;
      w[SR_IM_HI:SR_IM_LO]  = s.im;
      w[SR_EXL_BIT]         = s.exl;
      w[SR_IE_BIT]          = s.ie;
      return w;
   endfunction

   // Extract the writable SR fields from an mtc0 data word
   function automatic sr_t sr_from_word(input logic [DATA_W-1:0] w);
      sr_t s;
      s.im  = w[SR_IM_HI:SR_IM_LO];
      s.exl = w[SR_EXL_BIT];
      s.ie  = w[SR_IE_BIT];
      return s;
   endfunction

   // Place Cause fields into their architectural bit positions
   function automatic logic [DATA_W-1:0] cause_word(input cause_t c);
      logic [DATA_W-1:0] w;
      w                             = '0;
      w[CAUSE_BD_BIT]               = c.bd;
      w[CAUSE_IP_HI:CAUSE_IP_LO]    = c.ip;
      w[CAUSE_EXC_HI:CAUSE_EXC_LO]  = c.exc_code;
      return w;
   endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// M-stage <-> CP0 bus. The master modport is the pipeline side (drives the
// M-stage PC, exception info, mtc0/mfc0 and interrupt lines); the slave
// modport is the coprocessor (returns read data, EPC, Req and handler PC).
interface cp0_unit_if;
   import cp0_pkg::*;

   logic [ADDR_W-1:0]  CP0Addr;
   logic [DATA_W-1:0]  CP0In;
   logic               CP0WE;
   logic [DATA_W-1:0]  VPC;
   logic               BDIn;
   logic [EXC_W-1:0]   ExcCodeIn;
   logic               EXLClr;
   logic [HWINT_W-1:0] HWInt;
   logic [DATA_W-1:0]  CP0Out;
   logic [DATA_W-1:0]  EPCOut;
   logic               Req;
   logic [DATA_W-1:0]  HandlerPC;

   modport master (
      output CP0Addr, CP0In, CP0WE, VPC, BDIn, ExcCodeIn, EXLClr, HWInt,
      input  CP0Out, EPCOut, Req, HandlerPC
   );

   modport slave (
      input  CP0Addr, CP0In, CP0WE, VPC, BDIn, ExcCodeIn, EXLClr, HWInt,
      output CP0Out, EPCOut, Req, HandlerPC
   );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer, only built when CP0_TIMER_EN is defined.
// Ports: clk, reset (sync, active-high), wr_en/wr_addr/wr_data (mtc0 already
// qualified by the parent), count, compare, pending (sticky Count==Compare).
`ifdef CP0_TIMER_EN
module cp0_timer
   import cp0_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] count,
   output logic [DATA_W-1:0] compare,
   output logic              pending
);

   logic wr_count;
   logic wr_compare;

   assign wr_count   = wr_en && (wr_addr == CP0_COUNT);
   assign wr_compare = wr_en && (wr_addr == CP0_COMPARE);

   // Free-running count; a Compare write re-arms the sticky match flag
   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         compare <= '0;
         pending <= 1'b0;
      end else begin
         count <= wr_count ? wr_data : count + DATA_W'(1);
         if (wr_compare) begin
            compare <= wr_data;
            pending <= 1'b0;
         end else if (count == compare) begin
            pending <= 1'b1;
         end
      end
   end

endmodule
`endif

// File: rtl/cp0_unit.sv
// MIPS coprocessor 0 in the M stage: SR, Cause, EPC, PRId, mfc0/mtc0/eret
// and the exception/interrupt request that flushes the pipe.
// Ports: clk, reset (sync, active-high), bus (cp0_unit_if.slave):
//   in  CP0Addr, CP0In, CP0WE, VPC, BDIn, ExcCodeIn, EXLClr, HWInt
//   out CP0Out (mfc0 data), EPCOut (eret target), Req, HandlerPC
// Optional macro CP0_TIMER_EN adds Count(9)/Compare(11) and a timer
// interrupt on the IP[15] slot.
module cp0_unit
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID       = 32'h4C48_4431,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
   input logic       clk,
   input logic       reset,
   cp0_unit_if.slave bus
);

   sr_t               sr_q;
   cause_t            cause_q;
   logic [DATA_W-1:0] epc_q;

   logic               timer_pending;
   logic [DATA_W-1:0]  count_val;
   logic [DATA_W-1:0]  compare_val;
   logic [HWINT_W-1:0] ip_eff;
   logic               int_req;
   logic               exc_req;
   logic               req_raw;
   logic [DATA_W-1:0]  vpc_al;
   logic [DATA_W-1:0]  epc_next;
   logic [DATA_W-1:0]  rd_data;
   cause_t             cause_rd;
   logic               unused_vpc;

`ifdef CP0_TIMER_EN
   // mtc0 is dropped on a Req cycle, the timer sees the same qualification
   cp0_timer u_timer (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (bus.CP0WE & ~req_raw),
      .wr_addr (bus.CP0Addr),
      .wr_data (bus.CP0In),
      .count   (count_val),
      .compare (compare_val),
      .pending (timer_pending)
   );
`else
   assign timer_pending = 1'b0;
   assign count_val     = '0;
   assign compare_val   = '0;
`endif

   // Timer pending shares the HWInt[5] slot without an extra sampling stage
   assign ip_eff = {cause_q.ip[HWINT_W-1] | timer_pending, cause_q.ip[HWINT_W-2:0]};

   assign int_req = (|(ip_eff & sr_q.im)) & sr_q.ie & ~sr_q.exl;
   assign exc_req = (bus.ExcCodeIn != '0) & ~sr_q.exl;
   assign req_raw = int_req | exc_req;

   // Delay-slot instructions restart at the branch
   assign vpc_al     = {bus.VPC[DATA_W-1:2], 2'b00};
   assign epc_next   = bus.BDIn ? (vpc_al - DATA_W'(4)) : vpc_al;
   assign unused_vpc = ^bus.VPC[1:0];

   // mfc0 read mux
   always_comb begin
      rd_data     = '0;
      cause_rd    = cause_q;
      cause_rd.ip = ip_eff;
      case (bus.CP0Addr)
         CP0_SR:      rd_data = sr_word(sr_q);
         CP0_CAUSE:   rd_data = cause_word(cause_rd);
         CP0_EPC:     rd_data = epc_q;
         CP0_PRID:    rd_data = PRID;
         CP0_COUNT:   rd_data = count_val;
         CP0_COMPARE: rd_data = compare_val;
         default:     rd_data = '0;
      endcase
   end

   assign bus.Req       = ~reset & req_raw;
   assign bus.CP0Out    = reset ? '0 : rd_data;
   assign bus.EPCOut    = reset ? '0 : epc_q;
   assign bus.HandlerPC = HANDLER_PC;

   // Architectural state: exception entry beats mtc0 and eret
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q    <= '0;
         cause_q <= '0;
         epc_q   <= '0;
      end else begin
         cause_q.ip <= bus.HWInt;
         if (req_raw) begin
            sr_q.exl         <= 1'b1;
            cause_q.bd       <= bus.BDIn;
            cause_q.exc_code <= int_req ? EXC_INT : bus.ExcCodeIn;
            epc_q            <= epc_next;
         end else begin
            if (bus.EXLClr) begin
               sr_q.exl <= 1'b0;
            end
            if (bus.CP0WE) begin
               case (bus.CP0Addr)
                  CP0_SR:  sr_q  <= sr_from_word(bus.CP0In);
                  CP0_EPC: epc_q <= {bus.CP0In[DATA_W-1:2], 2'b00};
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: expected values are queued when
// stimulus is applied and popped when the outputs are sampled mid-cycle.
module tb_cp0_unit;
   import cp0_pkg::*;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   logic [31:0] exp_q[$];
   string       name_q[$];
   logic [31:0] obs[$];

   cp0_unit_if bus ();

   cp0_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string nm, input logic [31:0] v);
      name_q.push_back(nm);
      exp_q.push_back(v);
   endtask

   task automatic idle();
      bus.CP0WE     = 1'b0;
      bus.ExcCodeIn = '0;
      bus.EXLClr    = 1'b0;
      bus.BDIn      = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0]  addr_t[6];
      logic [31:0] val_t[6];
      logic [31:0] got, ev;
      string       nm;
      addr_t = '{CP0_SR, CP0_CAUSE, CP0_EPC, CP0_PRID, CP0_COMPARE, 5'd0};
`ifdef CP0_TIMER_EN
      val_t  = '{32'h0, 32'h0, 32'h0, 32'h4C48_4431, 32'hFFFF_FFF0, 32'h0};
`else
      val_t  = '{32'h0, 32'h0, 32'h0, 32'h4C48_4431, 32'h0, 32'h0};
`endif
      reset       = 1'b1;
      idle();
      bus.HWInt   = '0;
      bus.VPC     = 32'h0000_1234;
      bus.CP0In   = '0;
      bus.CP0Addr = CP0_PRID;
      repeat (2) cyc();
      push("rst_req", 32'h0);
      push("rst_cp0out", 32'h0);
      push("rst_epcout", 32'h0);
      push("handler_pc", 32'h0000_4180);
      @(negedge clk);
      obs.push_back(32'(bus.Req));
      obs.push_back(bus.CP0Out);
      obs.push_back(bus.EPCOut);
      obs.push_back(bus.HandlerPC);
      while (obs.size() > 0) begin
         got = obs.pop_front(); ev = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
         if (got !== ev) begin errors++; $display("FAIL %s: got %h expected %h", nm, got, ev); end
      end
      cyc();
      // First non-reset cycle: park Compare far away (ignored without the timer)
      reset       = 1'b0;
      bus.CP0WE   = 1'b1;
      bus.CP0Addr = CP0_COMPARE;
      bus.CP0In   = 32'hFFFF_FFF0;
      cyc();
      bus.CP0WE = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.CP0Addr = addr_t[i];
         push($sformatf("rst_read_%0d", addr_t[i]), val_t[i]);
         push("rst_req_idle", 32'h0);
         @(negedge clk);
         obs.push_back(bus.CP0Out);
         obs.push_back(32'(bus.Req));
         while (obs.size() > 0) begin
            got = obs.pop_front(); ev = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
            if (got !== ev) begin errors++; $display("FAIL %s: got %h expected %h", nm, got, ev); end
         end
         cyc();
      end
   endtask

   task automatic test_interrupt();
      logic [31:0] got, ev;
      string       nm;
      bus.HWInt   = 6'b000100;
      bus.CP0WE   = 1'b1;
      bus.CP0Addr = CP0_SR;
      bus.CP0In   = 32'h0000_FC01;
      push("int_req_before_sr", 32'h0);
      @(negedge clk);
      obs.push_back(32'(bus.Req));
      cyc();
      bus.CP0WE   = 1'b0;
      bus.VPC     = 32'h0000_2008;
      bus.CP0Addr = CP0_CAUSE;
      push("int_req", 32'h1);
      @(negedge clk);
      obs.push_back(32'(bus.Req));
      cyc();
      bus.HWInt = '0;
      push("int_cause", 32'h0000_1000);
      push("int_req_masked", 32'h0);
      @(negedge clk);
      obs.push_back(bus.CP0Out);
      obs.push_back(32'(bus.Req));
      cyc();
      bus.CP0Addr = CP0_SR;
      push("int_sr_exl", 32'h0000_FC03);
      push("int_epcout", 32'h0000_2008);
      @(negedge clk);
      obs.push_back(bus.CP0Out);
      obs.push_back(bus.EPCOut);
      cyc();
      bus.EXLClr = 1'b1;
      cyc();
      bus.EXLClr = 1'b0;
      push("int_sr_after_eret", 32'h0000_FC01);
      push("int_req_after_eret", 32'h0);
      @(negedge clk);
      obs.push_back(bus.CP0Out);
      obs.push_back(32'(bus.Req));
      while (obs.size() > 0) begin
         got = obs.pop_front(); ev = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
         if (got !== ev) begin errors++; $display("FAIL %s: got %h expected %h", nm, got, ev); end
      end
      cyc();
   endtask

   task automatic test_exception();
      logic [31:0] got, ev;
      string       nm;
      // Overflow in a delay slot, with a competing mtc0 EPC that must be dropped
      bus.VPC       = 32'h0000_3010;
      bus.BDIn      = 1'b1;
      bus.ExcCodeIn = EXC_OV;
      bus.CP0WE     = 1'b1;
      bus.CP0Addr   = CP0_EPC;
      bus.CP0In     = 32'h0000_5000;
      push("exc_req", 32'h1);
      @(negedge clk);
      obs.push_back(32'(bus.Req));
      cyc();
      idle();
      bus.ExcCodeIn = EXC_ADEL;
      bus.CP0Addr   = CP0_CAUSE;
      push("exc_nested_req", 32'h0);
      push("exc_cause", 32'h8000_0030);
      push("exc_epcout", 32'h0000_300C);
      @(negedge clk);
      obs.push_back(32'(bus.Req));
      obs.push_back(bus.CP0Out);
      obs.push_back(bus.EPCOut);
      cyc();
      bus.ExcCodeIn = '0;
      bus.CP0Addr   = CP0_EPC;
      push("exc_epc_read", 32'h0000_300C);
      @(negedge clk);
      obs.push_back(bus.CP0Out);
      cyc();
      bus.EXLClr = 1'b1;
      cyc();
      bus.EXLClr  = 1'b0;
      bus.CP0Addr = CP0_SR;
      push("exc_sr_after_eret", 32'h0000_FC01);
      push("exc_epcout_after_eret", 32'h0000_300C);
      @(negedge clk);
      obs.push_back(bus.CP0Out);
      obs.push_back(bus.EPCOut);
      while (obs.size() > 0) begin
         got = obs.pop_front(); ev = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
         if (got !== ev) begin errors++; $display("FAIL %s: got %h expected %h", nm, got, ev); end
      end
      cyc();
   endtask

   task automatic test_mtc0();
      logic [4:0]  addr_t[3];
      logic [31:0] val_t[3];
      logic [31:0] got, ev;
      string       nm;
      addr_t = '{CP0_EPC, CP0_CAUSE, CP0_SR};
      val_t  = '{32'h0000_1234, 32'h8000_0030, 32'h0000_FC01};
      bus.CP0WE   = 1'b1;
      bus.CP0Addr = CP0_EPC;
      bus.CP0In   = 32'h0000_1237;
      cyc();
      bus.CP0Addr = CP0_CAUSE;
      bus.CP0In   = 32'hFFFF_FFFF;
      cyc();
      bus.CP0Addr = CP0_SR;
      bus.CP0In   = 32'hFFFF_FC01;
      cyc();
      bus.CP0WE = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.CP0Addr = addr_t[i];
         push($sformatf("mtc0_read_%0d", addr_t[i]), val_t[i]);
         @(negedge clk);
         obs.push_back(bus.CP0Out);
         got = obs.pop_front(); ev = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
         if (got !== ev) begin errors++; $display("FAIL %s: got %h expected %h", nm, got, ev); end
         cyc();
      end
      push("mtc0_epcout", 32'h0000_1234);
      @(negedge clk);
      obs.push_back(bus.EPCOut);
      got = obs.pop_front(); ev = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (got !== ev) begin errors++; $display("FAIL %s: got %h expected %h", nm, got, ev); end
      cyc();
   endtask

   task automatic test_priority();
      logic [31:0] got, ev;
      string       nm;
      bus.HWInt = 6'b000001;
      push("prio_req_before_ip", 32'h0);
      @(negedge clk);
      obs.push_back(32'(bus.Req));
      cyc();
      bus.ExcCodeIn = EXC_RI;
      bus.VPC       = 32'h0000_4000;
      push("prio_req", 32'h1);
      @(negedge clk);
      obs.push_back(32'(bus.Req));
      cyc();
      bus.ExcCodeIn = '0;
      bus.HWInt     = '0;
      bus.CP0Addr   = CP0_CAUSE;
      push("prio_cause_int_wins", 32'h0000_0400);
      push("prio_epcout", 32'h0000_4000);
      @(negedge clk);
      obs.push_back(bus.CP0Out);
      obs.push_back(bus.EPCOut);
      cyc();
      bus.EXLClr = 1'b1;
      cyc();
      bus.EXLClr  = 1'b0;
      bus.CP0Addr = CP0_SR;
      push("prio_sr_after_eret", 32'h0000_FC01);
      push("prio_req_after_eret", 32'h0);
      @(negedge clk);
      obs.push_back(bus.CP0Out);
      obs.push_back(32'(bus.Req));
      while (obs.size() > 0) begin
         got = obs.pop_front(); ev = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
         if (got !== ev) begin errors++; $display("FAIL %s: got %h expected %h", nm, got, ev); end
      end
      cyc();
   endtask

`ifdef CP0_TIMER_EN
   task automatic test_timer();
      logic [31:0] got, ev;
      string       nm;
      bus.CP0WE   = 1'b1;
      bus.CP0Addr = CP0_COMPARE;
      bus.CP0In   = 32'd5;
      cyc();
      bus.CP0Addr = CP0_SR;
      bus.CP0In   = 32'h0000_8001;
      cyc();
      bus.CP0Addr = CP0_COUNT;
      bus.CP0In   = 32'd0;
      cyc();
      bus.CP0WE = 1'b0;
      for (int i = 0; i < 6; i++) begin
         push($sformatf("tmr_count_%0d", i), 32'(i));
         push($sformatf("tmr_req_idle_%0d", i), 32'h0);
         @(negedge clk);
         obs.push_back(bus.CP0Out);
         obs.push_back(32'(bus.Req));
         while (obs.size() > 0) begin
            got = obs.pop_front(); ev = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
            if (got !== ev) begin errors++; $display("FAIL %s: got %h expected %h", nm, got, ev); end
         end
         cyc();
      end
      push("tmr_req", 32'h1);
      @(negedge clk);
      obs.push_back(32'(bus.Req));
      cyc();
      bus.CP0Addr = CP0_CAUSE;
      push("tmr_cause", 32'h0000_8000);
      @(negedge clk);
      obs.push_back(bus.CP0Out);
      cyc();
      bus.CP0WE   = 1'b1;
      bus.CP0Addr = CP0_COMPARE;
      bus.CP0In   = 32'hFFFF_FFF0;
      cyc();
      bus.CP0WE   = 1'b0;
      bus.CP0Addr = CP0_CAUSE;
      push("tmr_cause_cleared", 32'h0);
      @(negedge clk);
      obs.push_back(bus.CP0Out);
      while (obs.size() > 0) begin
         got = obs.pop_front(); ev = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
         if (got !== ev) begin errors++; $display("FAIL %s: got %h expected %h", nm, got, ev); end
      end
      cyc();
      bus.EXLClr = 1'b1;
      cyc();
      bus.EXLClr = 1'b0;
   endtask
`endif

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_interrupt();
      test_exception();
      test_mtc0();
      test_priority();
`ifdef CP0_TIMER_EN
      test_timer();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
